// File: rtl/pipe_mux_stage_if.sv
// Handshake bundle for pipe_mux_stage.
//   slave  : the stage itself (consumes in_*, out_ready, flush; drives in_ready, out_*, err_sticky)
//   master : the surrounding pipeline (drives inputs, observes outputs)
interface pipe_mux_stage_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic                    err_sticky;

    modport master (
        output in_data, in_sel, in_valid, out_ready, flush,
        input  in_ready, out_data, out_sel_err, out_valid, err_sticky
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready, flush,
        output in_ready, out_data, out_sel_err, out_valid, err_sticky
    );
endinterface

// File: rtl/pipe_mux_stage.sv
// N:1 operand-select mux feeding a two-entry elastic output stage.
// The selected input is captured on the accepted beat into a main register
// (which drives the outputs) or a skid register. in_ready is decoded from the
// state register only, so out_ready never reaches in_ready combinationally.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipe_mux_stage_if.slave (in_data/in_sel/in_valid/in_ready,
//                out_data/out_sel_err/out_valid/out_ready, flush, err_sticky)
module pipe_mux_stage #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_mux_stage_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_data_q;
    logic             main_err_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;
    logic             sticky_q;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept;
    logic             pop;
    logic             main_ld;
    logic             main_from_skid;
    logic             skid_ld;

    // Input select; anything not matching a real input index is an error beat.
    always_comb begin
        cap_data = RESET_VAL;
        cap_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                cap_data = bus.in_data[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    assign accept = bus.in_valid && (state_q != FULL);
    assign pop    = (state_q != EMPTY) && bus.out_ready;

    // Occupancy next-state and register load enables.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_ld = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d = FULL;
                    skid_ld = 1'b1;
                end else if (accept && pop) begin
                    main_ld = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything, including a beat accepted this cycle.
        if (bus.flush) begin
            state_d        = EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
        end
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= RESET_VAL;
            main_err_q  <= 1'b0;
            skid_data_q <= RESET_VAL;
            skid_err_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (main_ld) begin
                main_data_q <= cap_data;
                main_err_q  <= cap_err;
            end else if (main_from_skid) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (skid_ld) begin
                skid_data_q <= cap_data;
                skid_err_q  <= cap_err;
            end
            // Sticky sees every accepted bad select, even one dropped by flush.
            if (accept && cap_err) begin
                sticky_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = (state_q != FULL);
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_data    = main_data_q;
    assign bus.out_sel_err = main_err_q;
    assign bus.err_sticky  = sticky_q;
endmodule

// File: tb/tb_pipe_mux_stage.sv
// Self-checking bench for pipe_mux_stage: a NUM_IN=4 instance checked against a
// queue model, and a NUM_IN=3 instance for out-of-range select behaviour.
module tb_pipe_mux_stage;
    logic clk;
    logic rst_n;

    pipe_mux_stage_if #(.WIDTH(32), .NUM_IN(4)) if4 ();
    pipe_mux_stage_if #(.WIDTH(32), .NUM_IN(3)) if3 ();

    pipe_mux_stage #(.WIDTH(32), .NUM_IN(4), .RESET_VAL(32'h0)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    pipe_mux_stage #(.WIDTH(32), .NUM_IN(3), .RESET_VAL(32'hDEAD_BEEF)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    logic [31:0] mq[$];   // model FIFO contents of u4, head = oldest
    logic [31:0] got[$];  // values u4 handed downstream
    bit          last_acc;

    // One clock: model decides accept/pop from its own occupancy, then updates.
    task automatic tick();
        bit          acc;
        bit          pp;
        bit          fl;
        bit          rs;
        logic [31:0] v;
        acc = if4.in_valid && (mq.size() < 2);
        pp  = (mq.size() > 0) && if4.out_ready;
        fl  = if4.flush;
        rs  = rst_n;
        v   = if4.in_data[int'(if4.in_sel)*32 +: 32];
        if (if4.out_valid && if4.out_ready) got.push_back(if4.out_data);
        @(posedge clk);
        #1;
        last_acc = acc && rs;
        if (!rs) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc && !fl) mq.push_back(v);
            if (fl) mq.delete();
        end
    endtask

    task automatic idle_inputs();
        if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_data = '0;
        if4.out_ready = 1'b0; if4.flush = 1'b0;
        if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_data = '0;
        if3.out_ready = 1'b0; if3.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", if4.out_valid); end
        n_tests++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", if4.in_ready); end
        n_tests++; if (if4.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", if4.out_data); end
        n_tests++; if (if4.out_sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b want 0", if4.out_sel_err); end
        n_tests++; if (if4.err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", if4.err_sticky); end
        n_tests++; if (if3.out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_u3_data: got %h want deadbeef", if3.out_data); end
        tick();
        n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_stream();
        logic [1:0]  sels [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
        logic [31:0] exps [4] = '{32'h44, 32'h11, 32'h33, 32'h22};
        if4.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        if4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1;
            if4.in_sel   = sels[i];
            tick();
            n_tests++; if (if4.out_valid !== 1'b1 || if4.out_data !== exps[i]) begin
                n_fail++; $display("FAIL stream[%0d]: got v=%b d=%h want v=1 d=%h", i, if4.out_valid, if4.out_data, exps[i]);
            end
            n_tests++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, if4.in_ready); end
        end
        if4.in_valid = 1'b0;
        tick();
        n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] beats [3] = '{32'hA, 32'hB, 32'hC};
        int idx = 0;
        got.delete();
        if4.out_ready = 1'b0;
        if4.in_sel    = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if4.in_valid = 1'b1;
            if4.in_data  = {96'h0, beats[idx]};
            tick();
            if (last_acc) idx++;
        end
        n_tests++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        n_tests++; if (if4.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", if4.in_ready); end
        n_tests++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'hA) begin
            n_fail++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=a", if4.out_valid, if4.out_data);
        end
        if4.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (idx < 3) begin
                if4.in_valid = 1'b1;
                if4.in_data  = {96'h0, beats[idx]};
            end else begin
                if4.in_valid = 1'b0;
            end
            tick();
            if (last_acc) idx++;
        end
        n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_tests++; if (got[i] !== beats[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], beats[i]); end
            end
        end
        if4.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        if4.out_ready = 1'b0;
        if4.in_sel    = 2'd1;
        if4.in_valid  = 1'b1;
        if4.in_data   = {64'h0, 32'h55, 32'h0};
        tick();
        if4.in_data   = {64'h0, 32'h66, 32'h0};
        tick();
        n_tests++; if (if4.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got in_ready=%b want 0", if4.in_ready); end
        if4.in_data = {64'h0, 32'h77, 32'h0};
        if4.flush   = 1'b1;
        tick();
        if4.flush    = 1'b0;
        if4.in_valid = 1'b0;
        n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", if4.out_valid); end
        n_tests++; if (if4.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", if4.in_ready); end
        // Flush in ONE while a beat is accepted: that beat is dropped too.
        if4.in_valid = 1'b1;
        if4.in_data  = {64'h0, 32'h88, 32'h0};
        tick();
        if4.in_data  = {64'h0, 32'h99, 32'h0};
        if4.flush    = 1'b1;
        tick();
        n_tests++; if (!last_acc) begin n_fail++; $display("FAIL flush_accept: got accept=0 want 1"); end
        if4.flush     = 1'b0;
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle[%0d]: got %b want 0", c, if4.out_valid); end
        end
        n_tests++; if (got.size() != 0) begin n_fail++; $display("FAIL flush_leak: got %0d beats want 0", got.size()); end
    endtask

    task automatic test_reset_mid();
        if4.out_ready = 1'b0;
        if4.in_sel    = 2'd2;
        if4.in_valid  = 1'b1;
        if4.in_data   = {32'h0, 32'h13, 64'h0};
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_hs: got v=%b r=%b want v=0 r=1", if4.out_valid, if4.in_ready);
        end
        n_tests++; if (if4.out_data !== 32'h0 || if4.out_sel_err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_data: got d=%h e=%b want d=0 e=0", if4.out_data, if4.out_sel_err);
        end
        if4.out_ready = 1'b1;
        if4.in_data   = {32'h0, 32'h5A, 64'h0};
        tick();
        n_tests++; if (if4.out_valid !== 1'b1 || if4.out_data !== 32'h5A) begin
            n_fail++; $display("FAIL rstmid_flow: got v=%b d=%h want v=1 d=5a", if4.out_valid, if4.out_data);
        end
        if4.in_valid = 1'b0;
        tick();
        n_tests++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drain: got %b want 0", if4.out_valid); end
    endtask

    task automatic test_out_of_range();
        if3.in_data   = {32'h33, 32'h22, 32'h11};
        if3.out_ready = 1'b1;
        if3.in_valid  = 1'b1;
        if3.in_sel    = 2'd3;
        tick();
        n_tests++; if (if3.out_valid !== 1'b1 || if3.out_data !== 32'hDEAD_BEEF || if3.out_sel_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_beat: got v=%b d=%h e=%b want v=1 d=deadbeef e=1", if3.out_valid, if3.out_data, if3.out_sel_err);
        end
        n_tests++; if (if3.err_sticky !== 1'b1) begin n_fail++; $display("FAIL oor_sticky: got %b want 1", if3.err_sticky); end
        if3.in_sel = 2'd1;
        tick();
        n_tests++; if (if3.out_data !== 32'h22 || if3.out_sel_err !== 1'b0) begin
            n_fail++; $display("FAIL oor_next: got d=%h e=%b want d=22 e=0", if3.out_data, if3.out_sel_err);
        end
        if3.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        n_tests++; if (if3.err_sticky !== 1'b1) begin n_fail++; $display("FAIL oor_hold: got %b want 1", if3.err_sticky); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++; if (if3.err_sticky !== 1'b0 || if3.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL oor_reset: got s=%b v=%b want s=0 v=0", if3.err_sticky, if3.out_valid);
        end
        if3.out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if4.in_valid  = ($urandom_range(0, 3) != 0);
            if4.in_sel    = 2'($urandom);
            if4.in_data   = {$urandom, $urandom, $urandom, $urandom};
            if4.out_ready = ($urandom_range(0, 2) != 0);
            if4.flush     = ($urandom_range(0, 24) == 0);
            tick();
            n_tests++; if (if4.out_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, if4.out_valid, mq.size() > 0);
            end
            n_tests++; if (if4.in_ready !== (mq.size() < 2)) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, if4.in_ready, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                n_tests++; if (if4.out_data !== mq[0] || if4.out_sel_err !== 1'b0) begin
                    n_fail++; $display("FAIL rand_data[%0d]: got d=%h e=%b want d=%h e=0", c, if4.out_data, if4.out_sel_err, mq[0]);
                end
            end
            n_tests++; if (if4.err_sticky !== 1'b0) begin n_fail++; $display("FAIL rand_sticky[%0d]: got %b want 0", c, if4.err_sticky); end
        end
        if4.flush    = 1'b0;
        if4.in_valid = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_tests  = 0;
        n_fail   = 0;
        last_acc = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_mux_stage.md
# pipe_mux_stage

Parametrised N:1 operand-select mux with a registered, two-entry elastic output stage (valid/ready handshake, flush). It replaces ad-hoc 2:1 select logic at pipeline boundaries of the pipelined RISC-V core, e.g. forwarding/operand selection between ID and EX. Selection happens on the accepted beat. The selected value is then buffered so that back-pressure never creates a combinational path from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 32, bit width of each data input and the output
- `NUM_IN`, 4, number of data inputs (≥2); select width `SEL_W = $clog2(NUM_IN)` is a derived localparam
- `RESET_VAL`, '0, value driven on `out_data` after reset and on out-of-range selects
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_data`  in  NUM_IN*WIDTH  flattened inputs; input k = `in_data[k*WIDTH +: WIDTH]`
- `in_sel`  in  SEL_W  input index to capture
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept a beat this cycle
- `out_data`  out  WIDTH  selected value of the oldest buffered beat
- `out_sel_err`  out  1  oldest buffered beat had `in_sel >= NUM_IN`
- `out_valid`  out  1  `out_data`/`out_sel_err` hold a beat
- `out_ready`  in  1  downstream consumes the beat this cycle
- `flush`  in  1  discard all buffered beats (branch mispredict / trap)
- `err_sticky`  out  1  set on any accepted out-of-range select; cleared only by reset

## Operation
- Storage: main register (drives outputs) + skid register. Each holds {data, sel_err}.
- State machine on occupancy:
  - EMPTY: 0 entries
  - ONE: main valid
  - FULL: main and skid valid
- Accept = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- Captured value = input `in_sel` if `in_sel < NUM_IN`. Otherwise it is `RESET_VAL` with sel_err=1, and `err_sticky` is set.
- Transitions (no flush):
  - EMPTY + accept → ONE (beat into main)
  - ONE + accept & !pop → FULL (beat into skid)
  - ONE + pop & !accept → EMPTY
  - ONE + accept & pop → ONE (new beat into main)
  - FULL + pop → ONE (skid moves to main)
  - FULL + no pop → FULL
  - otherwise hold
- `in_ready` = (state != FULL), decoded from the state register only; no combinational dependence on `out_ready` or `in_valid`.
- `out_valid` = (state != EMPTY).
- Order is strictly FIFO. `out_data`/`out_sel_err` are stable while `out_valid && !out_ready`.
- `flush`:
  - next state EMPTY; beats in main and skid are discarded.
  - An accept in the same cycle is discarded (the handshake completes but the beat is dropped); `err_sticky` is still updated by that beat.
  - A pop in the same cycle completes normally.
  - `out_data` is not required to change on flush; only `out_valid` drops.
- Unused data registers are not cleared except by reset.

## Timing
- Reset (`rst_n` low at a rising edge), values from the following cycle:
  - state EMPTY
  - `in_ready`=1, `out_valid`=0
  - `out_data`=RESET_VAL, `out_sel_err`=0, `err_sticky`=0
- Reset has priority over flush and handshakes. Reset mid-transfer drops all beats.
- Latency: a beat accepted at edge t appears on outputs after edge t (`out_valid`=1 in cycle t+1) when the stage was EMPTY, or when it was ONE with a pop at t.
- Throughput: 1 beat/cycle sustained with `out_ready`=1.
- One stall cycle of `out_ready`=0 is absorbed by the skid register. `in_ready` falls the cycle after FULL is entered.
- `in_ready` rises the cycle after a pop from FULL.

## Test plan
- Reset then idle: hold `rst_n`=0 two edges, then release → `out_valid`=0, `in_ready`=1, `out_data`=0, `err_sticky`=0.
- Streaming select, `out_ready`=1: WIDTH=32, NUM_IN=4, inputs {0x11,0x22,0x33,0x44}, `in_sel` cycles 3,0,2,1 → `out_data` 0x44,0x11,0x33,0x22 on consecutive cycles, each one cycle after accept.
- Back-pressure: send beats A=0xA, B=0xB, C=0xC back-to-back with `out_ready`=0 → A, B accepted; `in_ready`=0 while FULL; C is held upstream. Raise `out_ready` → A, B, C delivered in order, none lost or duplicated.
- Out-of-range select: NUM_IN=3, `in_sel`=3 → `out_data`=RESET_VAL, `out_sel_err`=1, `err_sticky`=1. Sticky remains 1 after later valid beats and until reset.
- Flush: FULL with `out_ready`=0, assert `flush` together with `in_valid` → next cycle `out_valid`=0, state EMPTY, `in_ready`=1. The concurrent beat never appears on the output.
- Reset mid-operation: FULL, pulse `rst_n`=0 for one edge → all outputs at reset values the next cycle. Subsequent beats flow with 1-cycle latency.
